serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: D = (A - B) mod 2^WIDTH, Br = (A < B).
// One bit pair is processed per clock, LSB first, through a full-subtractor
// step built from two chained half-subtractor cells. The borrow is registered
// between cycles. The result word is assembled in a shift register and only
// published to D/Br on the final shift edge, so partial results never appear
// on the outputs.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only in IDLE
//   A      in   WIDTH  minuend, captured on the accepting edge
//   B      in   WIDTH  subtrahend, captured on the accepting edge
//   busy   out  1      high while bits are being shifted
//   done   out  1      one-cycle pulse; D/Br valid from this cycle on
//   D      out  WIDTH  (A - B) mod 2^WIDTH, held until the next completion
//   Br     out  1      final borrow, 1 iff A < B (unsigned)
//
// Timing: start accepted at edge E0 -> busy for WIDTH cycles -> done for one
// cycle -> IDLE. Back-to-back throughput is one operation per WIDTH+2 cycles.
// -----------------------------------------------------------------------------

// Half-subtractor cell: difference and borrow-out of a - b.
module half_subtractor (
  input  logic i_a,
  input  logic i_b,
  output logic o_d,
  output logic o_br
);
  assign o_d  = i_a ^ i_b;
  assign o_br = ~i_a & i_b;
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Br
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_br;

  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;

  // ---------------------------------------------------------------------------
  // Full-subtractor step: stage 1 subtracts the operand bits, stage 2 subtracts
  // the incoming borrow. At most one stage can borrow, so OR merges them.
  // ---------------------------------------------------------------------------
  half_subtractor u_stage1 (
    .i_a  (r_ra[0]),
    .i_b  (r_rb[0]),
    .o_d  (w_d1),
    .o_br (w_b1)
  );

  half_subtractor u_stage2 (
    .i_a  (w_d1),
    .i_b  (r_borrow),
    .o_d  (w_d),
    .o_br (w_b2)
  );

  assign w_borrow_next = w_b1 | w_b2;

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  assign w_accept = (r_state == IDLE) && start;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift && (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees a value on every path, so no
  // latch is inferred even if a case arm forgets to assign.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, borrow, bit counter, result assembly.
  // D/Br are written only on the final shift edge so they hold the previous
  // result through IDLE and through the whole next SHIFT phase.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra     <= '0;
      r_rb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_br     <= 1'b0;
    end else if (w_accept) begin
      r_ra     <= A;
      r_rb     <= B;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (w_shift) begin
      r_ra     <= {1'b0, r_ra[WIDTH-1:1]};
      r_rb     <= {1'b0, r_rb[WIDTH-1:1]};
      r_res    <= w_res_next;
      r_cnt    <= r_cnt + 1'b1;
      r_borrow <= w_borrow_next;
      if (w_last) begin
        r_d  <= w_res_next;
        r_br <= w_borrow_next;
      end
    end
  end

  // Status decoded straight from the state register: glitch-free.
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign D    = r_d;
  assign Br   = r_br;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Reference model: tracks the number of cycles since the last accepted start
// and, on completion, publishes (A - B) mod 2^W and (A < B) computed with plain
// arithmetic on the operands captured at the accepting edge. A compare process
// checks busy/done/D/Br against the model every falling edge. Directed
// operations additionally check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Br;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Br    (Br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_age = 0          : idle
  //   m_age = 1..W       : busy (cycles since acceptance)
  //   m_age = W+1        : done cycle, new result visible
  // ---------------------------------------------------------------------------
  int           m_age;
  logic [W-1:0] m_d;
  logic         m_br;
  logic [W-1:0] m_pend_d;
  logic         m_pend_br;
  int           m_accepts;

  initial begin
    m_age     = 0;
    m_d       = '0;
    m_br      = 1'b0;
    m_pend_d  = '0;
    m_pend_br = 1'b0;
    m_accepts = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0;
      m_d   <= '0;
      m_br  <= 1'b0;
    end else if (m_age == 0) begin
      if (start) begin
        m_pend_d  <= W'(A - B);
        m_pend_br <= (A < B);
        m_age     <= 1;
        m_accepts <= m_accepts + 1;
      end
    end else if (m_age == W) begin
      m_d   <= m_pend_d;
      m_br  <= m_pend_br;
      m_age <= W + 1;
    end else if (m_age == W + 1) begin
      m_age <= 0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_age >= 1 && m_age <= W));
    check("done", 32'(done), 32'(m_age == W + 1));
    check("D",    32'(D),    32'(m_d));
    check("Br",   32'(Br),   32'(m_br));
  end

  // ---------------------------------------------------------------------------
  // One operation: pulse start, scramble operands after capture, wait (bounded)
  // for done, then check the literal expectation.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_br);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    for (int i = 0; i < W + 4 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("op_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("lit_D",  32'(D),  32'(exp_d));
      check("lit_Br", 32'(Br), 32'(exp_br));
    end
  endtask

  initial begin
    int           done_cnt;
    bit           prev_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_D",    32'(D),    32'd0);
    check("rst_Br",   32'(Br),   32'd0);
    rst_n = 1'b1;

    // Directed literals
    run_op(8'd200, 8'd55,  8'd145,  1'b0);
    run_op(8'd5,   8'd10,  8'hFB,   1'b1);
    run_op(8'd0,   8'd1,   8'hFF,   1'b1);
    run_op(8'hAA,  8'hAA,  8'h00,   1'b0);
    run_op(8'd0,   8'd0,   8'h00,   1'b0);
    run_op(8'hFF,  8'h00,  8'hFF,   1'b0);

    // Previous result held through the next SHIFT phase
    run_op(8'd200, 8'd55, 8'd145, 1'b0);
    @(negedge clk);
    A     = 8'd3;
    B     = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_D",    32'(D),    32'd145);
    check("hold_Br",   32'(Br),   32'd0);
    repeat (W + 2) @(negedge clk);
    check("after_hold_D",  32'(D),  32'd159);
    check("after_hold_Br", 32'(Br), 32'd1);

    // Reset in the middle of an operation
    @(negedge clk);
    A     = 8'd9;
    B     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_D",    32'(D),    32'd0);
    check("mid_rst_Br",   32'(Br),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", 32'(done_cnt), 32'd0);
    run_op(8'd9, 8'd3, 8'd6, 1'b0);

    // start held high with operands changing every cycle: one op per W+2
    @(negedge clk);
    done_cnt  = 0;
    prev_done = 1'b0;
    start     = 1'b1;
    for (int i = 0; i < 5 * (W + 2); i++) begin
      A = W'($urandom);
      B = W'($urandom);
      @(negedge clk);
      if (done) done_cnt++;
      check("done_not_twice", 32'(prev_done && done), 32'd0);
      prev_done = done;
    end
    start = 1'b0;
    check("held_start_ops", 32'(done_cnt), 32'd5);
    repeat (W + 3) @(negedge clk);

    // Randomized operations with random idle gaps
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n == 0) rb = ra;
      if (n == 1) begin ra = '0; rb = '1; end
      run_op(ra, rb, W'(ra - rb), ra < rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
